// File: rtl/vm_pkg.sv
// Vending-machine constants shared by state_transitions, change_dispenser and LED_display.
// Holds the coin indices, the denomination values and the dispenser FSM encoding.
package vm_pkg;

  localparam int NUM_COINS = 5;

  localparam int COIN_1  = 0;
  localparam int COIN_5  = 1;
  localparam int COIN_10 = 2;
  localparam int COIN_20 = 3;
  localparam int COIN_50 = 4;

  localparam logic [7:0] VAL_1  = 8'd1;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_50 = 8'd50;

  typedef logic [NUM_COINS-1:0] coin_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EMIT,
    ST_GAP,
    ST_DONE
  } disp_state_e;

  // Largest coin not exceeding amt; all-zero when amt is zero.
  function automatic coin_vec_t pick_coin(input logic [7:0] amt);
    coin_vec_t c;
    c = '0;
    if (amt >= VAL_50)      c[COIN_50] = 1'b1;
    else if (amt >= VAL_20) c[COIN_20] = 1'b1;
    else if (amt >= VAL_10) c[COIN_10] = 1'b1;
    else if (amt >= VAL_5)  c[COIN_5]  = 1'b1;
    else if (amt >= VAL_1)  c[COIN_1]  = 1'b1;
    return c;
  endfunction

  function automatic logic [7:0] coin_value(input coin_vec_t c);
    return ({8{c[COIN_1]}}  & VAL_1)  |
           ({8{c[COIN_5]}}  & VAL_5)  |
           ({8{c[COIN_10]}} & VAL_10) |
           ({8{c[COIN_20]}} & VAL_20) |
           ({8{c[COIN_50]}} & VAL_50);
  endfunction

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter used for pacing; expired_o marks the last cycle of a loaded
// interval (count of 1), so loading N yields N enabled cycles before expiry is acted on.
module gap_counter #(
  parameter int GAP_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q <= ONE);

endmodule

// File: rtl/change_dispenser.sv
// Turns a change amount into paced one-hot coin pulses, greedy 50/20/10/5/1.
// All outputs decode from registered state; start outside IDLE is dropped.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int PULSE_GAP = 50_000_000,
  parameter int GAP_W     = 26
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] change_money,
  output logic       busy,
  output logic [4:0] coin_pulse,
  output logic [7:0] remaining,
  output logic [3:0] coin_total,
  output logic       done
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PULSE_GAP - 1);
  localparam bit               HAS_GAP  = (PULSE_GAP > 1);

  disp_state_e state_q, state_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [3:0]  total_q, total_d;
  coin_vec_t   denom_q, denom_d;
  logic        gap_expired;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    denom_d     = denom_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = change_money;
          total_d     = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == 8'd0) begin
          state_d = ST_DONE;
        end else begin
          denom_d = pick_coin(remaining_q);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Selection guarantees the coin fits, so this cannot underflow.
        remaining_d = remaining_q - coin_value(denom_q);
        total_d     = total_q + 4'd1;
        state_d     = HAS_GAP ? ST_GAP : ST_SELECT;
      end
      ST_GAP: begin
        if (gap_expired) state_d = ST_SELECT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      total_q     <= '0;
      denom_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      denom_q     <= denom_d;
    end
  end

  gap_counter #(
    .GAP_W(GAP_W)
  ) u_gap (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (state_q == ST_EMIT),
    .load_val_i (GAP_LOAD),
    .en_i       (state_q == ST_GAP),
    .expired_o  (gap_expired)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign coin_pulse = (state_q == ST_EMIT) ? denom_q : '0;
  assign remaining  = remaining_q;
  assign coin_total = total_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with PULSE_GAP=4, one with PULSE_GAP=1.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st4 = 1'b0, st1 = 1'b0;
  logic [7:0] m4 = '0, m1 = '0;

  logic       d4_busy, d1_busy, d4_done, d1_done;
  logic [4:0] d4_pulse, d1_pulse;
  logic [7:0] d4_rem, d1_rem;
  logic [3:0] d4_tot, d1_tot;

  logic       sel1 = 1'b0;
  logic       o_busy, o_done;
  logic [4:0] o_pulse;
  logic [7:0] o_rem;
  logic [3:0] o_tot;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int inj_off = -1;
  logic [7:0] inj_amt = '0;

  always #5 clk = ~clk;

  change_dispenser #(.PULSE_GAP(4), .GAP_W(4)) dut4 (
    .sys_clk(clk), .sys_rst(rst), .start(st4), .change_money(m4),
    .busy(d4_busy), .coin_pulse(d4_pulse), .remaining(d4_rem),
    .coin_total(d4_tot), .done(d4_done)
  );

  change_dispenser #(.PULSE_GAP(1), .GAP_W(4)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .start(st1), .change_money(m1),
    .busy(d1_busy), .coin_pulse(d1_pulse), .remaining(d1_rem),
    .coin_total(d1_tot), .done(d1_done)
  );

  assign o_busy  = sel1 ? d1_busy  : d4_busy;
  assign o_done  = sel1 ? d1_done  : d4_done;
  assign o_pulse = sel1 ? d1_pulse : d4_pulse;
  assign o_rem   = sel1 ? d1_rem   : d4_rem;
  assign o_tot   = sel1 ? d1_tot   : d4_tot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] hot(input int v);
    case (v)
      1:       return 5'b00001;
      5:       return 5'b00010;
      10:      return 5'b00100;
      20:      return 5'b01000;
      50:      return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic drive_start(input bit g1, input logic s, input logic [7:0] amt);
    if (g1) begin st1 = s; m1 = amt; end
    else    begin st4 = s; m4 = amt; end
  endtask

  // Called on a negedge; returns on the negedge where done is seen (or on timeout).
  task automatic run_job(input bit g1, input logic [7:0] amt);
    int p, off, nseen, sum;
    bit pend, got_done;
    p = g1 ? 1 : 4;
    sel1 = g1;
    drive_start(g1, 1'b1, amt);
    @(negedge clk);
    drive_start(g1, 1'b0, amt);
    off = 1;
    check("busy_rise", o_busy, 1);
    nseen = 0; sum = 0; pend = 0; got_done = 0;
    while (!got_done && off < 300) begin
      @(negedge clk);
      off++;
      drive_start(g1, (off == inj_off), inj_amt);
      if (pend) begin
        check("remaining", o_rem, 32'(int'(amt) - sum));
        check("coin_total", o_tot, nseen);
        pend = 0;
      end
      if (o_pulse != 5'b0) begin
        if (nseen < exp_q.size()) begin
          check("pulse_val", o_pulse, hot(exp_q[nseen]));
          check("pulse_time", off, 2 + nseen * (p + 1));
          sum += exp_q[nseen];
        end else begin
          check("extra_pulse", o_pulse, 0);
        end
        nseen++;
        pend = 1;
      end
      if (o_done) begin
        got_done = 1;
        check("done_time", off, 2 + exp_q.size() * (p + 1));
        check("n_coins", nseen, exp_q.size());
        check("final_total", o_tot, exp_q.size());
        check("final_rem", o_rem, 0);
        check("busy_at_done", o_busy, 1);
      end else begin
        check("busy_mid", o_busy, 1);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    drive_start(g1, 1'b0, 8'd0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("busy_fall", o_busy, 0);
    check("done_one_cycle", o_done, 0);
    check("total_hold", o_tot, exp_q.size());
    check("rem_zero_idle", o_rem, 0);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge clk);
    check("rst_busy4", d4_busy, 0);
    check("rst_pulse4", d4_pulse, 0);
    check("rst_rem4", d4_rem, 0);
    check("rst_tot4", d4_tot, 0);
    check("rst_done4", d4_done, 0);
    check("rst_busy1", d1_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", d4_busy, 0);

    // Zero amount: done at k+2, no pulses.
    exp_q.delete();
    run_job(0, 8'd0);
    idle_check();

    // 37 with a second start (99) injected during the job: must be ignored.
    exp_q = '{20, 10, 5, 1, 1};
    inj_off = 4; inj_amt = 8'd99;
    run_job(0, 8'd37);
    inj_off = -1;
    idle_check();

    exp_q = '{50, 20, 20, 5, 1, 1, 1, 1};
    run_job(0, 8'd99);
    idle_check();

    exp_q = '{50, 50, 50, 50, 20, 20, 5, 1, 1, 1, 1};
    run_job(1, 8'd249);
    idle_check();

    exp_q = '{50, 50, 50, 50, 50, 5};
    run_job(1, 8'd255);
    idle_check();

    // Start while done is high is dropped; the next cycle's start is taken.
    exp_q = '{5};
    run_job(1, 8'd5);
    drive_start(1, 1'b1, 8'd77);
    @(negedge clk);
    check("start_in_done_ignored", o_busy, 0);
    exp_q = '{20};
    run_job(1, 8'd20);
    idle_check();

    // Asynchronous reset between the 2nd and 3rd coin of 37.
    sel1 = 0;
    drive_start(0, 1'b1, 8'd37);
    @(negedge clk);
    drive_start(0, 1'b0, 8'd0);
    repeat (8) @(negedge clk);
    check("pre_rst_rem", d4_rem, 7);
    check("pre_rst_tot", d4_tot, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", d4_busy, 0);
    check("arst_pulse", d4_pulse, 0);
    check("arst_rem", d4_rem, 0);
    check("arst_tot", d4_tot, 0);
    check("arst_done", d4_done, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (d4_done || d4_pulse != 5'b0 || d4_busy) bad++;
    end
    check("no_done_after_rst", bad, 0);
    exp_q = '{5, 1};
    run_job(0, 8'd6);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
